// File: rtl/sram_1rw1r_wmask.sv
// sram_1rw1r_wmask
// Behavioural 1RW + 1R synchronous SRAM with per-lane write mask,
// selectable 1- or 2-cycle read latency and a hardware zero-init sweep
// that runs after every reset.
//
// Ports
//   clk0            clock, rising edge
//   rst0_n          asynchronous active-low reset
//   ready           high once the init sweep has zeroed the whole array
//   csb0/web0       port 0 select / write enable (both active low)
//   wmask0          port 0 lane write enables
//   addr0/din0      port 0 address / write data
//   dout0/dvalid0   port 0 read data / one-cycle "dout0 updated" strobe
//   csb1/addr1      port 1 (read-only) select / address
//   dout1/dvalid1   port 1 read data / one-cycle "dout1 updated" strobe
//
// State  | meaning
// -------+-------------------------------------------------------------
// INIT   | sweeping mem[0..RAM_DEPTH-1] to zero, both ports ignored
// RUN    | normal 1RW + 1R operation, ready high
module sram_1rw1r_wmask #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 7,
    parameter int NUM_WMASKS   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    output logic                  ready,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dvalid1
);

    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW        = DATA_WIDTH / NUM_WMASKS;

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("sram_1rw1r_wmask: READ_LATENCY must be 1 or 2");
        end
        if (DATA_WIDTH % NUM_WMASKS != 0) begin : g_bad_lanes
            $error("sram_1rw1r_wmask: DATA_WIDTH must be divisible by NUM_WMASKS");
        end
    endgenerate

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] sweep_cnt;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  run;
    logic                  wr_en0;
    logic                  rd_en0;
    logic                  rd_en1;
    logic [DATA_WIDTH-1:0] rd_word0;
    logic [DATA_WIDTH-1:0] rd_word1;

    // ready is registered alongside the state so it rises the cycle after
    // the last sweep write.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == {ADDR_WIDTH{1'b1}}) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state     <= ST_INIT;
                    sweep_cnt <= '0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

    assign run    = (state == ST_RUN);
    assign wr_en0 = run && !csb0 && !web0;
    assign rd_en0 = run && !csb0 &&  web0;
    assign rd_en1 = run && !csb1;

    // Array has no reset: the sweep is what clears it.
    always_ff @(posedge clk0) begin
        if (state == ST_INIT) begin
            mem[sweep_cnt] <= '0;
        end else if (wr_en0) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) begin
                    mem[addr0][i*LW +: LW] <= din0[i*LW +: LW];
                end
            end
        end
    end

    // Port 0 cannot read and write in the same cycle, so a plain array read
    // gives pre-write data for a read followed by a write.
    assign rd_word0 = mem[addr0];

    // Write-first for port 1: on a same-address collision the written lanes
    // are forwarded from din0, untouched lanes come from the array.
    always_comb begin
        rd_word1 = mem[addr1];
        if (wr_en0 && (addr0 == addr1)) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) begin
                    rd_word1[i*LW +: LW] = din0[i*LW +: LW];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] stg_d0;
            logic [DATA_WIDTH-1:0] stg_d1;
            logic                  stg_v0;
            logic                  stg_v1;

            always_ff @(posedge clk0 or negedge rst0_n) begin
                if (!rst0_n) begin
                    stg_d0  <= '0;
                    stg_d1  <= '0;
                    stg_v0  <= 1'b0;
                    stg_v1  <= 1'b0;
                    dout0   <= '0;
                    dout1   <= '0;
                    dvalid0 <= 1'b0;
                    dvalid1 <= 1'b0;
                end else begin
                    stg_v0 <= rd_en0;
                    stg_v1 <= rd_en1;
                    if (rd_en0) begin
                        stg_d0 <= rd_word0;
                    end
                    if (rd_en1) begin
                        stg_d1 <= rd_word1;
                    end
                    dvalid0 <= stg_v0;
                    dvalid1 <= stg_v1;
                    if (stg_v0) begin
                        dout0 <= stg_d0;
                    end
                    if (stg_v1) begin
                        dout1 <= stg_d1;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk0 or negedge rst0_n) begin
                if (!rst0_n) begin
                    dout0   <= '0;
                    dout1   <= '0;
                    dvalid0 <= 1'b0;
                    dvalid1 <= 1'b0;
                end else begin
                    dvalid0 <= rd_en0;
                    dvalid1 <= rd_en1;
                    if (rd_en0) begin
                        dout0 <= rd_word0;
                    end
                    if (rd_en1) begin
                        dout1 <= rd_word1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
module tb_sram_1rw1r_wmask;

    localparam int DEPTH = 128;

    logic        clk0;
    logic        rst0_n;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [6:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [6:0]  addr1;

    logic        ready_a, dvalid0_a, dvalid1_a;
    logic [31:0] dout0_a, dout1_a;
    logic        ready_b, dvalid0_b, dvalid1_b;
    logic [31:0] dout0_b, dout1_b;

    int checks = 0;
    int errors = 0;

    sram_1rw1r_wmask #(.READ_LATENCY(1)) u_lat1 (
        .clk0(clk0), .rst0_n(rst0_n), .ready(ready_a),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0_a), .dvalid0(dvalid0_a),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_a), .dvalid1(dvalid1_a)
    );

    sram_1rw1r_wmask #(.READ_LATENCY(2)) u_lat2 (
        .clk0(clk0), .rst0_n(rst0_n), .ready(ready_b),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0_b), .dvalid0(dvalid0_b),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_b), .dvalid1(dvalid1_b)
    );

    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    // Reference model: word array, edge count since reset release, and per
    // latency a queue of issued reads that surface L-1 edges after issue.
    logic [31:0] ref_mem [DEPTH];
    int          mcnt;
    logic [32:0] q0 [2][$];
    logic [32:0] q1 [2][$];
    logic [31:0] hd0 [2];
    logic [31:0] hd1 [2];
    logic        ev0 [2];
    logic        ev1 [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mcnt = 0;
        for (int k = 0; k < 2; k++) begin
            q0[k].delete();
            q1[k].delete();
            hd0[k] = '0;
            hd1[k] = '0;
            ev0[k] = 1'b0;
            ev1[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [32:0] i0;
        logic [32:0] i1;
        logic [32:0] o;
        i0 = '0;
        i1 = '0;
        if (mcnt < DEPTH) begin
            ref_mem[mcnt] = '0;
            mcnt++;
        end else begin
            if (!csb0 && web0) i0 = {1'b1, ref_mem[addr0]};
            if (!csb0 && !web0) begin
                for (int l = 0; l < 4; l++)
                    if (wmask0[l]) ref_mem[addr0][l*8 +: 8] = din0[l*8 +: 8];
            end
            if (!csb1) i1 = {1'b1, ref_mem[addr1]};
        end
        for (int k = 0; k < 2; k++) begin
            q0[k].push_back(i0);
            q1[k].push_back(i1);
            if (q0[k].size() > k) begin
                o = q0[k].pop_front();
                ev0[k] = o[32];
                if (o[32]) hd0[k] = o[31:0];
            end else begin
                ev0[k] = 1'b0;
            end
            if (q1[k].size() > k) begin
                o = q1[k].pop_front();
                ev1[k] = o[32];
                if (o[32]) hd1[k] = o[31:0];
            end else begin
                ev1[k] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        chk("ready_l1",   64'(ready_a),   64'(mcnt == DEPTH));
        chk("ready_l2",   64'(ready_b),   64'(mcnt == DEPTH));
        chk("dvalid0_l1", 64'(dvalid0_a), 64'(ev0[0]));
        chk("dvalid1_l1", 64'(dvalid1_a), 64'(ev1[0]));
        chk("dout0_l1",   64'(dout0_a),   64'(hd0[0]));
        chk("dout1_l1",   64'(dout1_a),   64'(hd1[0]));
        chk("dvalid0_l2", 64'(dvalid0_b), 64'(ev0[1]));
        chk("dvalid1_l2", 64'(dvalid1_b), 64'(ev1[1]));
        chk("dout0_l2",   64'(dout0_b),   64'(hd0[1]));
        chk("dout1_l2",   64'(dout1_b),   64'(hd1[1]));
    endtask

    task automatic tick();
        @(posedge clk0);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
        csb1 = 1'b1; addr1 = '0;
    endtask

    task automatic wr0(input logic [6:0] a, input logic [31:0] d, input logic [3:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    endtask

    task automatic rd0(input logic [6:0] a);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a; wmask0 = '0;
    endtask

    task automatic rd1(input logic [6:0] a);
        csb1 = 1'b0; addr1 = a;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready_a && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'(DEPTH));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();
        rst0_n = 1'b1;
        #2 rst0_n = 1'b0;
        #1;
        chk("rst_ready", 64'(ready_a), 64'(0));
        chk("rst_dvalid0", 64'(dvalid0_a), 64'(0));
        chk("rst_dout0", 64'(dout0_b), 64'(0));
        #20 rst0_n = 1'b1;

        // Test 1: sweep length, then zeros from the array
        wait_ready("ready_lat");
        rd0(7'd0); rd1(7'd64); tick();
        chk("t1_a0", 64'(dout0_a), 64'(0));
        chk("t1_v0", 64'(dvalid0_a), 64'(1));
        rd0(7'd127); rd1(7'd127); tick();
        chk("t1_v1", 64'(dvalid1_a), 64'(1));
        idle(); tick(); tick();

        // Test 2: full write, read on both ports
        wr0(7'd10, 32'hFACECAFE, 4'hF); tick();
        idle(); rd0(7'd10); rd1(7'd10); tick();
        chk("t2_p0", 64'(dout0_a), 64'(32'hFACECAFE));
        chk("t2_p1", 64'(dout1_a), 64'(32'hFACECAFE));
        idle(); tick();

        // Test 3: lane-masked write
        wr0(7'd10, 32'h12345678, 4'b0101); tick();
        idle(); rd0(7'd10); tick();
        chk("t3_merge", 64'(dout0_a), 64'(32'hFA34CA78));
        idle(); tick();

        // Test 4: write-first collision on port 1
        wr0(7'd5, 32'hDEADBEEF, 4'hF); rd1(7'd5); tick();
        chk("t4_coll", 64'(dout1_a), 64'(32'hDEADBEEF));
        idle(); tick();
        chk("t4_coll_l2", 64'(dout1_b), 64'(32'hDEADBEEF));

        // Read then write same address: read sees pre-write data
        rd0(7'd5); tick();
        wr0(7'd5, 32'h0BADF00D, 4'hF); tick();
        chk("rbw_l1", 64'(dout0_a), 64'(32'hDEADBEEF));
        idle(); tick();

        // Test 5: back-to-back reads, latency 2 timing
        wr0(7'd1, 32'h11, 4'hF); tick();
        wr0(7'd2, 32'h22, 4'hF); tick();
        wr0(7'd3, 32'h33, 4'hF); tick();
        idle(); tick();
        rd0(7'd1); tick();
        chk("t5_l2_v_n", 64'(dvalid0_b), 64'(0));
        chk("t5_l1_d1", 64'(dout0_a), 64'(32'h11));
        rd0(7'd2); tick();
        chk("t5_l2_v1", 64'(dvalid0_b), 64'(1));
        chk("t5_l2_d1", 64'(dout0_b), 64'(32'h11));
        rd0(7'd3); tick();
        chk("t5_l2_d2", 64'(dout0_b), 64'(32'h22));
        idle(); tick();
        chk("t5_l2_v3", 64'(dvalid0_b), 64'(1));
        chk("t5_l2_d3", 64'(dout0_b), 64'(32'h33));
        tick();
        chk("t5_l2_vend", 64'(dvalid0_b), 64'(0));

        // Randomised traffic on a narrow address window to force collisions
        repeat (1500) begin
            csb0   = ($urandom_range(0, 3) == 0);
            web0   = 1'($urandom_range(0, 1));
            wmask0 = 4'($urandom);
            addr0  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 15));
            din0   = $urandom;
            csb1   = ($urandom_range(0, 3) == 0);
            addr1  = 7'($urandom_range(0, 15));
            tick();
        end

        // Test 6: reset with reads in flight
        idle(); wr0(7'd10, 32'hA5A51234, 4'hF); tick();
        idle(); rd0(7'd10); rd1(7'd10); tick();
        rd0(7'd11); rd1(7'd10);
        #2 rst0_n = 1'b0;
        #1;
        chk("t6_ready_l1", 64'(ready_a), 64'(0));
        chk("t6_ready_l2", 64'(ready_b), 64'(0));
        chk("t6_dout0_l1", 64'(dout0_a), 64'(0));
        chk("t6_dout1_l1", 64'(dout1_a), 64'(0));
        chk("t6_dv0_l1", 64'(dvalid0_a), 64'(0));
        chk("t6_dout0_l2", 64'(dout0_b), 64'(0));
        chk("t6_dout1_l2", 64'(dout1_b), 64'(0));
        chk("t6_dv1_l2", 64'(dvalid1_b), 64'(0));
        model_reset();
        #12 rst0_n = 1'b1;
        wait_ready("ready_lat2");
        rd0(7'd10); rd1(7'd10); tick();
        chk("t6_a10_p0", 64'(dout0_a), 64'(0));
        chk("t6_a10_v0", 64'(dvalid0_a), 64'(1));
        idle(); tick();
        chk("t6_a10_l2v", 64'(dvalid1_b), 64'(1));
        chk("t6_a10_l2d", 64'(dout1_b), 64'(0));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
